bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) sitting directly downstream of the calculator divider. It consumes Q or R when the divider's output_vld is high and produces packed BCD digits, a sign flag and a leading-zero blank mask for the 7-segment display driver. It uses the same handshake style as the divider: output_vld is high whenever the block is idle and holding a finished result.

---
 rtl/bin2bcd_seq_pkg.sv | 30 +++
 rtl/bin2bcd_seq_digit_adj.sv | 12 +
 rtl/bin2bcd_seq.sv | 128 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t      : FSM state encoding (IDLE, CONV, FIN)
//   BCD_W        : width of one BCD digit
//   min_digits() : smallest digit count able to hold 2^bits - 1
package bin2bcd_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   localparam int BCD_W = 4;

   // Smallest d with 10^d > 2^bits - 1.
   function automatic int min_digits(input int bits);
      longint unsigned limit;
      longint unsigned pow10;
      int              d;
      limit = (64'd1 << bits) - 64'd1;
      pow10 = 64'd10;
      d     = 1;
      while (pow10 <= limit) begin
         pow10 = pow10 * 64'd10;
         d++;
      end
      return d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// One BCD digit correction cell for the shift-and-add-3 algorithm.
//   digit    : current 4-bit BCD digit
//   adjusted : digit + 3 when digit >= 5, otherwise digit unchanged
module bcd_digit_adj
(
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock.
//   clk, rst   : clock and synchronous active-high reset
//   BIN        : binary value, SIGNED selects two's complement interpretation
//   input_vld  : request; accepted only while idle (output_vld high)
//   BCD        : packed digits, units in [3:0]
//   NEG        : result is negative
//   BLANK      : leading-zero mask, bit 0 always 0
//   output_vld : idle and outputs hold a finished result
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int BITS   = 16,
   parameter int DIGITS = 5
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [BITS-1:0]         BIN,
   input  logic                    SIGNED,
   input  logic                    input_vld,
   output logic [BCD_W*DIGITS-1:0] BCD,
   output logic                    NEG,
   output logic [DIGITS-1:0]       BLANK,
   output logic                    output_vld
);

   localparam int CW = $clog2(BITS + 1);
   localparam int AW = BCD_W * DIGITS;

   generate
      if (DIGITS < min_digits(BITS)) begin : g_bad_digits
         $error("DIGITS too small to represent 2^BITS-1");
      end
   endgenerate

   state_t            state_reg;
   logic [CW-1:0]     cnt_reg;
   logic [BITS-1:0]   shift_reg;
   logic [AW-1:0]     acc_reg;
   logic              neg_reg;
   logic [AW-1:0]     bcd_reg;
   logic              neg_out_reg;
   logic [DIGITS-1:0] blank_reg;
   logic              vld_reg;

   logic [AW-1:0]     adj;
   logic [DIGITS-1:0] blank_next;
   logic [BITS-1:0]   mag;
   logic              top_carry_unused;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         bcd_digit_adj u_adj (
            .digit    (acc_reg[gi*BCD_W +: BCD_W]),
            .adjusted (adj[gi*BCD_W +: BCD_W])
         );
      end

      // Digit i is blanked when it and every more significant digit are zero.
      for (gi = 1; gi < DIGITS; gi++) begin : g_blank
         assign blank_next[gi] = ~|acc_reg[AW-1:gi*BCD_W];
      end
   endgenerate

   assign blank_next[0] = 1'b0;

   // The digit count guarantees the top digit never carries out.
   assign top_carry_unused = adj[AW-1];

   // Magnitude of a negative signed value; 2^(BITS-1) maps onto itself as unsigned.
   always_comb begin
      mag = BIN;
      if (SIGNED && BIN[BITS-1])
         mag = (~BIN) + {{(BITS-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         shift_reg   <= '0;
         acc_reg     <= '0;
         neg_reg     <= 1'b0;
         bcd_reg     <= '0;
         neg_out_reg <= 1'b0;
         blank_reg   <= ~DIGITS'(1);
         vld_reg     <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (input_vld) begin
                  shift_reg <= mag;
                  acc_reg   <= '0;
                  neg_reg   <= SIGNED & BIN[BITS-1];
                  cnt_reg   <= CW'(BITS);
                  vld_reg   <= 1'b0;
                  state_reg <= ST_CONV;
               end
            end
            ST_CONV: begin
               acc_reg   <= {adj[AW-2:0], shift_reg[BITS-1]};
               shift_reg <= shift_reg << 1;
               cnt_reg   <= cnt_reg - CW'(1);
               if (cnt_reg == CW'(1))
                  state_reg <= ST_FIN;
            end
            ST_FIN: begin
               bcd_reg     <= acc_reg;
               neg_out_reg <= neg_reg;
               blank_reg   <= blank_next;
               vld_reg     <= 1'b1;
               state_reg   <= ST_IDLE;
            end
            default: begin
               vld_reg   <= 1'b1;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign BCD        = bcd_reg;
   assign NEG        = neg_out_reg;
   assign BLANK      = blank_reg;
   assign output_vld = vld_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (BITS=16, DIGITS=5) using a result scoreboard.
module tb_bin2bcd_seq;

   localparam int BITS   = 16;
   localparam int DIGITS = 5;

   typedef struct packed {
      logic [19:0] bcd;
      logic        neg;
      logic [4:0]  blank;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] BIN = 16'd0;
   logic        SIGNED = 1'b0;
   logic        input_vld = 1'b0;
   logic [19:0] BCD;
   logic        NEG;
   logic [4:0]  BLANK;
   logic        output_vld;

   res_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   bin2bcd_seq #(.BITS(BITS), .DIGITS(DIGITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .BIN        (BIN),
      .SIGNED     (SIGNED),
      .input_vld  (input_vld),
      .BCD        (BCD),
      .NEG        (NEG),
      .BLANK      (BLANK),
      .output_vld (output_vld)
   );

   always #5 clk = ~clk;

   // Reference: decimal digits by division, blank bit i set when value < 10^i.
   function automatic res_t model(input logic [15:0] b, input logic s);
      res_t        r;
      int unsigned m;
      int unsigned v;
      int unsigned p;
      m = (s && b[15]) ? (32'd65536 - 32'(b)) : 32'(b);
      r.neg = s && b[15];
      v = m;
      for (int i = 0; i < 5; i++) begin
         r.bcd[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      r.blank = 5'b0;
      p = 1;
      for (int i = 1; i < 5; i++) begin
         p = p * 10;
         r.blank[i] = (m < p);
      end
      return r;
   endfunction

   function automatic res_t pop_exp();
      res_t r;
      r = '1;
      if (sb.size() > 0)
         r = sb.pop_front();
      return r;
   endfunction

   task automatic send(input logic [15:0] b, input logic s, input bit push);
      @(posedge clk); #1;
      BIN = b; SIGNED = s; input_vld = 1'b1;
      if (push) sb.push_back(model(b, s));
      @(posedge clk); #1;
      input_vld = 1'b0;
   endtask

   // Counts cycles (after the accept edge) until output_vld returns high.
   task automatic wait_idle(output int lowcnt);
      lowcnt = 0;
      while (!output_vld && lowcnt < 40) begin
         lowcnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++; if (output_vld !== 1'b1) begin n_bad++; $display("FAIL reset_vld got=%b want=1", output_vld); end
      n_cmp++; if (BCD !== 20'h00000) begin n_bad++; $display("FAIL reset_bcd got=%h want=00000", BCD); end
      n_cmp++; if (NEG !== 1'b0) begin n_bad++; $display("FAIL reset_neg got=%b want=0", NEG); end
      n_cmp++; if (BLANK !== 5'b11110) begin n_bad++; $display("FAIL reset_blank got=%b want=11110", BLANK); end
      $display("txn reset: bcd=%h neg=%b blank=%b vld=%b", BCD, NEG, BLANK, output_vld);
   endtask

   task automatic test_unsigned(input logic [15:0] b);
      res_t e;
      int   lc;
      send(b, 1'b0, 1'b1);
      wait_idle(lc);
      e = pop_exp();
      n_cmp++; if (lc != 17) begin n_bad++; $display("FAIL uns_latency bin=%0d got=%0d want=17", b, lc); end
      n_cmp++; if (BCD !== e.bcd) begin n_bad++; $display("FAIL uns_bcd bin=%0d got=%h want=%h", b, BCD, e.bcd); end
      n_cmp++; if (NEG !== e.neg) begin n_bad++; $display("FAIL uns_neg bin=%0d got=%b want=%b", b, NEG, e.neg); end
      n_cmp++; if (BLANK !== e.blank) begin n_bad++; $display("FAIL uns_blank bin=%0d got=%b want=%b", b, BLANK, e.blank); end
      $display("txn unsigned bin=%0d: bcd=%h neg=%b blank=%b low=%0d", b, BCD, NEG, BLANK, lc);
   endtask

   task automatic test_signed(input logic [15:0] b);
      res_t e;
      int   lc;
      send(b, 1'b1, 1'b1);
      wait_idle(lc);
      e = pop_exp();
      n_cmp++; if (lc != 17) begin n_bad++; $display("FAIL sgn_latency bin=%h got=%0d want=17", b, lc); end
      n_cmp++; if (BCD !== e.bcd) begin n_bad++; $display("FAIL sgn_bcd bin=%h got=%h want=%h", b, BCD, e.bcd); end
      n_cmp++; if (NEG !== e.neg) begin n_bad++; $display("FAIL sgn_neg bin=%h got=%b want=%b", b, NEG, e.neg); end
      n_cmp++; if (BLANK !== e.blank) begin n_bad++; $display("FAIL sgn_blank bin=%h got=%b want=%b", b, BLANK, e.blank); end
      $display("txn signed bin=%h: bcd=%h neg=%b blank=%b low=%0d", b, BCD, NEG, BLANK, lc);
   endtask

   task automatic test_ignore_busy();
      res_t e;
      int   lc;
      int   drops;
      send(16'd1234, 1'b0, 1'b1);
      lc = 0;
      while (!output_vld && lc < 40) begin
         lc++;
         if (lc == 3) begin BIN = 16'd9; input_vld = 1'b1; end
         else input_vld = 1'b0;
         @(posedge clk); #1;
      end
      input_vld = 1'b0;
      e = pop_exp();
      n_cmp++; if (lc != 17) begin n_bad++; $display("FAIL busy_latency got=%0d want=17", lc); end
      n_cmp++; if (BCD !== e.bcd) begin n_bad++; $display("FAIL busy_bcd got=%h want=%h", BCD, e.bcd); end
      n_cmp++; if (BLANK !== e.blank) begin n_bad++; $display("FAIL busy_blank got=%b want=%b", BLANK, e.blank); end
      drops = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (!output_vld || BCD !== e.bcd) drops++;
      end
      n_cmp++; if (drops != 0) begin n_bad++; $display("FAIL busy_not_queued got=%0d want=0", drops); end
      $display("txn busy-ignore bin=1234: bcd=%h blank=%b low=%0d", BCD, BLANK, lc);
   endtask

   task automatic test_reset_mid_conv();
      res_t e;
      int   lc;
      send(16'd999, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      n_cmp++; if (output_vld !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b want=0", output_vld); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++; if (output_vld !== 1'b1) begin n_bad++; $display("FAIL midrst_vld got=%b want=1", output_vld); end
      n_cmp++; if (BCD !== 20'h00000) begin n_bad++; $display("FAIL midrst_bcd got=%h want=00000", BCD); end
      n_cmp++; if (BLANK !== 5'b11110) begin n_bad++; $display("FAIL midrst_blank got=%b want=11110", BLANK); end
      $display("txn reset mid-conv: bcd=%h blank=%b vld=%b", BCD, BLANK, output_vld);
      send(16'd42, 1'b0, 1'b1);
      wait_idle(lc);
      e = pop_exp();
      n_cmp++; if (BCD !== e.bcd) begin n_bad++; $display("FAIL after_rst_bcd got=%h want=%h", BCD, e.bcd); end
      n_cmp++; if (BLANK !== e.blank) begin n_bad++; $display("FAIL after_rst_blank got=%b want=%b", BLANK, e.blank); end
      $display("txn after reset bin=42: bcd=%h blank=%b low=%0d", BCD, BLANK, lc);
   endtask

   task automatic test_back_to_back();
      res_t e;
      int   rises;
      int   last_rise;
      int   high_run;
      int   glitches;
      logic prev;
      bit   seen_first;
      rises = 0; last_rise = -1; high_run = 0; glitches = 0;
      prev = output_vld; seen_first = 1'b0;
      for (int i = 0; i < 3; i++) sb.push_back(model(16'd7, 1'b0));
      @(posedge clk); #1;
      BIN = 16'd7; SIGNED = 1'b0; input_vld = 1'b1;
      for (int c = 0; c < 80 && rises < 3; c++) begin
         @(posedge clk); #1;
         if (seen_first && BCD !== 20'h00007) glitches++;
         if (output_vld) high_run++;
         if (!output_vld && prev && rises > 0) begin
            n_cmp++; if (high_run != 1) begin n_bad++; $display("FAIL b2b_idle_gap got=%0d want=1", high_run); end
         end
         if (!output_vld) high_run = 0;
         if (output_vld && !prev) begin
            rises++;
            e = pop_exp();
            n_cmp++; if (BCD !== e.bcd) begin n_bad++; $display("FAIL b2b_bcd got=%h want=%h", BCD, e.bcd); end
            if (last_rise >= 0) begin
               n_cmp++; if (c - last_rise != 18) begin n_bad++; $display("FAIL b2b_period got=%0d want=18", c - last_rise); end
            end
            $display("txn back-to-back #%0d bin=7: bcd=%h blank=%b cycle=%0d", rises, BCD, BLANK, c);
            last_rise = c;
            seen_first = 1'b1;
         end
         prev = output_vld;
      end
      input_vld = 1'b0;
      n_cmp++; if (rises != 3) begin n_bad++; $display("FAIL b2b_count got=%0d want=3", rises); end
      n_cmp++; if (glitches != 0) begin n_bad++; $display("FAIL b2b_glitch got=%0d want=0", glitches); end
   endtask

   initial begin
      test_reset();
      test_unsigned(16'd0);
      test_unsigned(16'd65535);
      test_unsigned(16'd805);
      test_signed(16'hFFFF);
      test_signed(16'h8000);
      test_signed(16'hFF9C);
      test_signed(16'h7FFF);
      test_ignore_busy();
      test_reset_mid_conv();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
